// File: rtl/gsim_pkg.sv
// Shared constants, state encoding and packing helpers for the Gauss-Seidel host interface.
package gsim_pkg;

  localparam int N          = 16;
  localparam int DW         = 16;
  localparam int XW         = 32;
  localparam int LOAD_WORDS = N * N + N;
  localparam int CW         = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    CAPTURE,
    UNLOAD,
    RELEASE
  } state_t;

  // The solver expects A column-major on its bus although the host streams it row-major.
  function automatic int a_offset(input logic [3:0] r, input logic [3:0] c);
    return int'(c) * N * DW + int'(r) * DW;
  endfunction

  function automatic int b_offset(input logic [3:0] r);
    return int'(r) * DW;
  endfunction

endpackage

// File: rtl/gsim_result_buf.sv
// 16x32 result capture buffer with a ready/valid read port.
// Data is registered so it cannot move while the consumer stalls.
module gsim_result_buf
  import gsim_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic [N*XW-1:0] x,
  input  logic            ready,
  output logic            valid,
  output logic [XW-1:0]   data,
  output logic            last_hs
);

  logic [XW-1:0] mem [N];
  logic [3:0]    idx;
  logic          hs;

  assign hs      = valid && ready;
  assign last_hs = hs && (idx == 4'(N - 1));

  // Snapshot all solver results in one cycle.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) mem[i] <= x[i*XW +: XW];
    end
  end

  // Read port: first word is taken straight from the bus, later words from the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      idx   <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= x[XW-1:0];
      idx   <= '0;
    end else if (hs) begin
      if (last_hs) begin
        valid <= 1'b0;
      end else begin
        idx  <= idx + 4'd1;
        data <= mem[idx + 4'd1];
      end
    end
  end

endmodule

// File: rtl/gsim_host_if.sv
// Host-side initiator for the Gauss-Seidel solver: packs the word stream into A/B,
// runs the solver and streams the 16 results back out.
// Optional watchdog in WAIT_DONE enabled by macro GSIM_HOST_TIMEOUT_EN (adds o_timeout).
//
// state     | meaning
// IDLE      | one cycle after reset
// LOAD      | accepting 256 A words then 16 B words
// START     | solver enable just raised, arm logic cleared
// WAIT_DONE | waiting for a fresh done (stale done ignored until done seen low)
// CAPTURE   | snapshot solver results
// UNLOAD    | stream 16 results out
// RELEASE   | drop enable, clear word counter
module gsim_host_if
  import gsim_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
)
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DW-1:0]     i_in_data,
  output logic [N*N*DW-1:0] o_a,
  output logic [N*DW-1:0]   o_b,
  output logic              o_module_en,
  input  logic              i_done,
  input  logic [N*XW-1:0]   i_x,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [XW-1:0]     o_out_data,
  output logic              o_busy
`ifdef GSIM_HOST_TIMEOUT_EN
  ,
  output logic              o_timeout
`endif
);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          accept;
  logic          last_word;
  logic          unload_done;
  logic          tmo_hit;

  assign o_in_ready = (state == LOAD);
  assign accept     = i_in_valid && (state == LOAD);
  assign last_word  = accept && (cnt == CW'(LOAD_WORDS - 1));
  assign o_busy     = !((state == IDLE) || (state == LOAD));

`ifdef GSIM_HOST_TIMEOUT_EN
  logic [15:0] tcnt;

  assign tmo_hit = (state == WAIT_DONE) && !(i_done && armed) && (tcnt == 16'(TIMEOUT_CYC - 1));

  // Watchdog: counts cycles spent in WAIT_DONE, pulses o_timeout on expiry.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tcnt      <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= tmo_hit;
      if (state == WAIT_DONE) tcnt <= tcnt + 16'd1;
      else                    tcnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = LOAD;
      LOAD:      if (last_word) state_nx = START;
      START:     state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (i_done && armed) state_nx = CAPTURE;
        else if (tmo_hit)    state_nx = RELEASE;
      end
      CAPTURE:   state_nx = UNLOAD;
      UNLOAD:    if (unload_done) state_nx = RELEASE;
      RELEASE:   state_nx = LOAD;
      default:   state_nx = IDLE;
    endcase
  end

  // Word counter, solver enable and stale-done arming.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt         <= '0;
      armed       <= 1'b0;
      o_module_en <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + CW'(1);
      // Enable rises on the cycle the last word lands so the solver sees it during START.
      if (last_word) o_module_en <= 1'b1;
      if (state == START) armed <= 1'b0;
      if ((state == WAIT_DONE) && !i_done) armed <= 1'b1;
      if (state == RELEASE) begin
        o_module_en <= 1'b0;
        cnt         <= '0;
      end
    end
  end

  // Pack accepted words into the A/B buses; contents persist until overwritten.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_a <= '0;
      o_b <= '0;
    end else if (accept) begin
      if (!cnt[8]) o_a[a_offset(cnt[7:4], cnt[3:0]) +: DW] <= i_in_data;
      else         o_b[b_offset(cnt[3:0]) +: DW]           <= i_in_data;
    end
  end

  gsim_result_buf u_result_buf (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .capture (state == CAPTURE),
    .x       (i_x),
    .ready   (i_out_ready),
    .valid   (o_out_valid),
    .data    (o_out_data),
    .last_hs (unload_done)
  );

endmodule
